// File: rtl/riscboy_ppu_sprite_shifter.sv
// Per-sprite pixel engine: asks the AGU for line intersection, fetches tile
// words, seeks on left clip and shifts one pixel out per beam advance.
module riscboy_ppu_sprite_shifter #(
    parameter W_DATA     = 32,
    parameter W_COORD    = 9,
    parameter W_SHIFTCTR = $clog2(W_DATA)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_enable,
    input  logic                  cfg_tilesize,
    input  logic [2:0]            cfg_log_pixsize,
    input  logic                  start_line,
    input  logic                  pixel_advance,
    output logic                  agu_req,
    input  logic                  agu_ack,
    input  logic                  agu_active,
    input  logic [W_COORD-1:0]    agu_x_count,
    input  logic                  agu_must_seek,
    input  logic [W_SHIFTCTR-1:0] agu_shift_seek_target,
    output logic                  bus_vld,
    input  logic                  bus_rdy,
    output logic [4:0]            bus_postcount,
    input  logic [W_DATA-1:0]     bus_data,
    output logic                  out_vld,
    output logic [15:0]           out_pix,
    output logic                  stall
);

    localparam W_BITS = $clog2(W_DATA + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DRAW = 2'd3;

    logic [1:0]            state;
    logic [W_DATA-1:0]     sr;
    logic [W_BITS-1:0]     bits;
    logic [4:0]            rem;
    logic [W_COORD-1:0]    cd;
    logic [W_SHIFTCTR-1:0] seek;
    logic                  pend;
    logic                  discard;

    logic [4:0]         pixsize;
    logic [4:0]         tile_w;
    logic [W_COORD-1:0] pre_count;
    logic [15:0]        pix_mask;
    logic               drawing;
    logic               buf_empty;
    logic               need_fetch;
    logic               ack;
    logic               load;
    logic               shift;

    assign pixsize   = 5'd1 << cfg_log_pixsize;
    assign tile_w    = cfg_tilesize ? 5'd16 : 5'd8;
    assign pre_count = agu_x_count - W_COORD'(tile_w);
    assign pix_mask  = 16'hffff >> (5'd16 - pixsize);

    assign drawing    = state == S_DRAW;
    assign buf_empty  = bits == '0;
    assign need_fetch = (drawing || state == S_WAIT) && buf_empty && rem != 5'd0;

    // A fetch left in flight by start_line keeps bus_vld up; agu_req waits for it.
    assign bus_vld       = pend || need_fetch;
    assign bus_postcount = rem;
    assign agu_req       = state == S_REQ && !pend;

    assign out_vld = drawing && rem != 5'd0 && !buf_empty;
    assign stall   = drawing && rem != 5'd0 && buf_empty;
    assign out_pix = out_vld ? (sr[15:0] & pix_mask) : 16'h0;

    assign ack   = agu_req && agu_ack;
    assign load  = bus_vld && bus_rdy && !discard && !start_line;
    assign shift = out_vld && pixel_advance && !start_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sr      <= '0;
            bits    <= '0;
            rem     <= 5'd0;
            cd      <= '0;
            seek    <= '0;
            pend    <= 1'b0;
            discard <= 1'b0;
        end else begin
            pend <= bus_vld && !bus_rdy;
            if (bus_vld && bus_rdy)
                discard <= 1'b0;
            if (start_line) begin
                state <= cfg_enable ? S_REQ : S_IDLE;
                bits  <= '0;
                rem   <= 5'd0;
                cd    <= '0;
                seek  <= '0;
                if (bus_vld && !bus_rdy)
                    discard <= 1'b1;
            end else begin
                case (state)
                    S_REQ: begin
                        if (ack) begin
                            if (!agu_active) begin
                                state <= S_IDLE;
                            end else if (agu_must_seek) begin
                                rem   <= agu_x_count[4:0];
                                seek  <= agu_shift_seek_target;
                                cd    <= '0;
                                state <= S_DRAW;
                            end else begin
                                rem   <= tile_w;
                                seek  <= '0;
                                cd    <= pre_count;
                                state <= (pre_count == '0) ? S_DRAW : S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (pixel_advance) begin
                            cd <= cd - W_COORD'(1);
                            if (cd == W_COORD'(1))
                                state <= S_DRAW;
                        end
                    end
                    default: ;
                endcase
                if (load) begin
                    sr   <= bus_data >> seek;
                    bits <= W_BITS'(W_DATA) - W_BITS'(seek);
                    seek <= '0;
                end else if (shift) begin
                    sr   <= sr >> pixsize;
                    bits <= bits - W_BITS'(pixsize);
                    rem  <= rem - 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscboy_ppu_sprite_shifter.sv
// Bench for riscboy_ppu_sprite_shifter: pixel-queue model plus directed
// scanline scenarios with literal expectations.
`timescale 1ns/1ps
module tb_riscboy_ppu_sprite_shifter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_enable;
    logic        cfg_tilesize;
    logic [2:0]  cfg_log_pixsize;
    logic        start_line;
    logic        pixel_advance;
    logic        agu_req;
    logic        agu_ack;
    logic        agu_active;
    logic [8:0]  agu_x_count;
    logic        agu_must_seek;
    logic [4:0]  agu_shift_seek_target;
    logic        bus_vld;
    logic        bus_rdy;
    logic [4:0]  bus_postcount;
    logic [31:0] bus_data;
    logic        out_vld;
    logic [15:0] out_pix;
    logic        stall;

    riscboy_ppu_sprite_shifter dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .cfg_enable            (cfg_enable),
        .cfg_tilesize          (cfg_tilesize),
        .cfg_log_pixsize       (cfg_log_pixsize),
        .start_line            (start_line),
        .pixel_advance         (pixel_advance),
        .agu_req               (agu_req),
        .agu_ack               (agu_ack),
        .agu_active            (agu_active),
        .agu_x_count           (agu_x_count),
        .agu_must_seek         (agu_must_seek),
        .agu_shift_seek_target (agu_shift_seek_target),
        .bus_vld               (bus_vld),
        .bus_rdy               (bus_rdy),
        .bus_postcount         (bus_postcount),
        .bus_data              (bus_data),
        .out_vld               (out_vld),
        .out_pix               (out_pix),
        .stall                 (stall)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: sprite pixels still to show, pre-sprite countdown, fetched pixel queue.
    bit          m_active = 0;
    bit          m_disc = 0;
    bit          tb_expect_discard = 0;
    int          m_px = 0;
    int          m_pre = 0;
    int          m_seek = 0;
    logic [15:0] q[$];
    logic [15:0] shown[$];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_active = 0; m_disc = 0; m_px = 0; m_pre = 0; m_seek = 0;
            q.delete();
        end else if (start_line) begin
            m_active = 0; m_px = 0; m_pre = 0; m_seek = 0;
            q.delete();
            if (tb_expect_discard) m_disc = 1;
        end else begin
            if (pixel_advance && m_active) begin
                if (m_pre > 0) m_pre--;
                else if (m_px > 0 && q.size() > 0) begin
                    shown.push_back(q.pop_front());
                    m_px--;
                end
            end
            if (agu_ack) begin
                if (!agu_active) m_active = 0;
                else if (agu_must_seek) begin
                    m_active = 1; m_px = int'(agu_x_count[4:0]);
                    m_pre = 0; m_seek = int'(agu_shift_seek_target);
                end else begin
                    m_active = 1; m_px = cfg_tilesize ? 16 : 8;
                    m_pre = int'(agu_x_count) - m_px; m_seek = 0;
                end
            end
            if (bus_rdy) begin
                if (m_disc) m_disc = 0;
                else begin
                    int psz;
                    logic [31:0] w;
                    psz = 1 << cfg_log_pixsize;
                    w = bus_data >> m_seek;
                    for (int k = 0; k < (32 - m_seek) / psz; k++)
                        q.push_back(16'((w >> (k * psz)) & ((32'd1 << psz) - 1)));
                    m_seek = 0;
                end
            end
        end
    end

    int max_stall = 0;
    int cur_stall = 0;

    initial forever begin
        bit ev;
        @(negedge clk);
        if (rst_n) begin
            ev = m_active && m_pre == 0 && m_px > 0 && q.size() > 0;
            chk("out_vld", out_vld, ev);
            chk("stall", stall, m_active && m_pre == 0 && m_px > 0 && q.size() == 0);
            if (ev) chk("out_pix", out_pix, q[0]);
            cur_stall = stall ? cur_stall + 1 : 0;
            if (cur_stall > max_stall) max_stall = cur_stall;
        end
    end

    // Bus responder: answers after rsp_lat cycles of bus_vld, one-cycle rdy.
    int          rsp_lat = 0;
    int          rsp_count = 0;
    int          post_log[$];
    logic [31:0] data_q[$];

    initial begin
        int cnt = 0;
        bus_rdy = 0;
        bus_data = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || bus_rdy) begin
                bus_rdy = 0;
                cnt = 0;
            end else if (bus_vld) begin
                if (cnt >= rsp_lat) begin
                    bus_rdy = 1;
                    bus_data = (data_q.size() > 0) ? data_q.pop_front() : 32'h0;
                    rsp_count++;
                    if (!m_disc) begin
                        post_log.push_back(int'(bus_postcount));
                        chk("postcount_model", bus_postcount, m_px);
                    end
                end else cnt++;
            end else cnt = 0;
        end
    end

    task automatic pulse_start();
        @(negedge clk); start_line = 1;
        @(negedge clk); start_line = 0;
    endtask

    task automatic step_adv();
        @(negedge clk); pixel_advance = 1;
        @(negedge clk); pixel_advance = 0;
    endtask

    task automatic grant(input logic act, input logic [8:0] x,
                         input logic ms, input logic [4:0] tgt);
        int n = 0;
        do begin @(negedge clk); n++; end while (!agu_req && n < 20);
        if (!agu_req) chk("agu_req_timeout", agu_req, 1);
        agu_ack = 1; agu_active = act; agu_x_count = x;
        agu_must_seek = ms; agu_shift_seek_target = tgt;
        @(negedge clk);
        agu_ack = 0; agu_active = 0; agu_x_count = 0;
        agu_must_seek = 0; agu_shift_seek_target = 0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_agu_req"}, agu_req, 0);
        chk({nm, "_bus_vld"}, bus_vld, 0);
        chk({nm, "_postcount"}, bus_postcount, 0);
        chk({nm, "_out_vld"}, out_vld, 0);
        chk({nm, "_out_pix"}, out_pix, 0);
        chk({nm, "_stall"}, stall, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, sbase, c0, n;
        logic [15:0] exp_px[10];
        exp_px = '{16'hCC, 16'hDD, 16'h11, 16'h22, 16'h33,
                   16'h44, 16'h55, 16'h66, 16'h77, 16'h88};
        rst_n = 0; cfg_enable = 1; cfg_tilesize = 0; cfg_log_pixsize = 2;
        start_line = 0; pixel_advance = 0; agu_ack = 0; agu_active = 0;
        agu_x_count = 0; agu_must_seek = 0; agu_shift_seek_target = 0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk); rst_n = 1;
        @(negedge clk); chk("idle_req", agu_req, 0);

        // Inactive sprite: silent for the rest of the line.
        pulse_start();
        chk("req_after_start", agu_req, 1);
        grant(0, 9'd0, 0, 5'd0);
        repeat (8) begin
            @(negedge clk);
            chk("inact_bus_vld", bus_vld, 0);
            chk("inact_out_vld", out_vld, 0);
            chk("inact_req", agu_req, 0);
        end

        // 8 px, 4 bpp, no seek, 4 px ahead of the beam.
        data_q.push_back(32'h76543210); rsp_lat = 1; base = post_log.size();
        pulse_start();
        grant(1, 9'd12, 0, 5'd0);
        chk("first_fetch_vld", bus_vld, 1);
        chk("first_fetch_post", bus_postcount, 8);
        repeat (6) @(negedge clk);
        repeat (4) step_adv();
        for (int i = 0; i < 8; i++) begin
            chk("t2_vld", out_vld, 1);
            chk("t2_pix", out_pix, i);
            step_adv();
        end
        chk("t2_done_vld", out_vld, 0);
        repeat (6) begin @(negedge clk); chk("t2_no_refetch", bus_vld, 0); end
        chk("t2_fetches", post_log.size() - base, 1);
        chk("t2_post", post_log[base], 8);

        // 16 px, 8 bpp, left-clipped with seek, slow bus.
        cfg_tilesize = 1; cfg_log_pixsize = 3; rsp_lat = 5;
        data_q.push_back(32'hDDCCBBAA);
        data_q.push_back(32'h44332211);
        data_q.push_back(32'h88776655);
        base = post_log.size(); sbase = shown.size();
        pulse_start();
        grant(1, 9'd10, 1, 5'd16);
        repeat (9) @(negedge clk);
        chk("t3_pix0", out_pix, 16'hCC);
        step_adv();
        chk("t3_pix1", out_pix, 16'hDD);
        step_adv();
        for (int i = 0; i < 60 && m_px > 0; i++) step_adv();
        chk("t3_draw_done", m_px, 0);
        chk("t3_done_vld", out_vld, 0);
        chk("t3_fetches", post_log.size() - base, 3);
        chk("t3_post0", post_log[base], 10);
        chk("t3_post1", post_log[base + 1], 8);
        chk("t3_post2", post_log[base + 2], 4);
        for (int i = 0; i < 10; i++) chk("t3_seq", shown[sbase + i], exp_px[i]);
        chk("t3_stall_run", max_stall >= 5, 1);

        // start_line while a fetch is outstanding.
        cfg_tilesize = 0; cfg_log_pixsize = 2; rsp_lat = 100;
        data_q.push_back(32'hFFFFFFFF);
        data_q.push_back(32'h01234567);
        pulse_start();
        grant(1, 9'd8, 0, 5'd0);
        repeat (3) @(negedge clk);
        chk("t4_pending_vld", bus_vld, 1);
        chk("t4_pending_stall", stall, 1);
        tb_expect_discard = 1;
        pulse_start();
        tb_expect_discard = 0;
        chk("t4_held_vld", bus_vld, 1);
        chk("t4_req_blocked", agu_req, 0);
        repeat (2) @(negedge clk);
        chk("t4_held_vld2", bus_vld, 1);
        chk("t4_req_blocked2", agu_req, 0);
        @(posedge clk); c0 = rsp_count; rsp_lat = 0;
        n = 0;
        do begin @(posedge clk); n++; end while (rsp_count == c0 && n < 10);
        chk("t4_rdy_seen", rsp_count != c0, 1);
        @(negedge clk);
        chk("t4_req_after", agu_req, 1);
        chk("t4_vld_dropped", bus_vld, 0);
        grant(1, 9'd8, 0, 5'd0);
        repeat (3) @(negedge clk);
        chk("t4_pix0", out_pix, 7);
        step_adv();
        chk("t4_pix1", out_pix, 6);
        step_adv();
        chk("t4_pix2", out_pix, 5);

        // Asynchronous reset mid-draw.
        #2 rst_n = 0;
        #1 chk_all_zero("async_rst");
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        chk("post_rst_req", agu_req, 0);
        chk("post_rst_vld", bus_vld, 0);
        chk("post_rst_out", out_vld, 0);
        pulse_start();
        chk("post_rst_req_rise", agu_req, 1);
        grant(0, 9'd0, 0, 5'd0);
        @(negedge clk);
        chk("post_rst_idle", agu_req, 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscboy_ppu_sprite_shifter.md
# riscboy_ppu_sprite_shifter

Per-sprite pixel engine that sits on the sprite-side ports of the PPU sprite AGU, one instance per sprite slot. Each scanline it asks the AGU for the sprite's X/Y intersection result, then fetches the sprite's tile data one bus word at a time, discarding leading pixels when the sprite is clipped on the left. It shifts out one pixel per beam advance to the blender, and raises a stall when its buffer runs dry mid-sprite.

## Interface
Parameters:
- W_DATA, 32, bus data width; shift register width.
- W_COORD, 9, beam coordinate width.
- W_SHIFTCTR, $clog2(W_DATA), seek target width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_enable  in  1  sprite enabled; sampled on start_line.
- cfg_tilesize  in  1  0: 8 px wide, 1: 16 px wide.
- cfg_log_pixsize  in  3  log2 bits per pixel, range 0–4; driven from MODE_LOG_PIXSIZE by the parent.
- start_line  in  1  one-cycle pulse at the start of each scanline.
- pixel_advance  in  1  beam moves one pixel this cycle.
- agu_req  out  1  coordinate request to the AGU.
- agu_ack  in  1  AGU grant; the agu_* results below are valid in the same cycle.
- agu_active  in  1  sprite intersects this line, right of the beam.
- agu_x_count  in  W_COORD  pixels from the beam to the sprite's right bound.
- agu_must_seek  in  1  beam is already inside the sprite.
- agu_shift_seek_target  in  W_SHIFTCTR  bits to discard from the first fetched word.
- bus_vld  out  1  fetch request.
- bus_rdy  in  1  data valid / transfer complete this cycle.
- bus_postcount  out  5  sprite pixels remaining, including the first pixel of this fetch.
- bus_data  in  W_DATA  fetch data.
- out_vld  out  1  sprite covers the current pixel; out_pix is valid.
- out_pix  out  16  current pixel, zero-extended, right-justified.
- stall  out  1  drawing, but the buffer is empty.

## Operation
- States: IDLE, REQ, WAIT, DRAW.
- Registers:
  - shift register sr, W_DATA bits.
  - valid-bit count bits, 0..W_DATA.
  - remaining pixel count rem, 0..16.
  - pre-sprite countdown cd, W_COORD bits.
  - flags pend (request outstanding) and discard.
- start_line, from any state:
  - Goes to REQ if cfg_enable, else to IDLE.
  - Clears bits, rem and cd.
  - If a fetch is pending (bus_vld=1, no rdy yet), bus_vld stays high until bus_rdy; that word is discarded (discard=1).
- REQ: agu_req=1 until the agu_ack cycle. In the ack cycle:
  - If !agu_active: go to IDLE for the rest of the line.
  - If agu_must_seek: rem=agu_x_count[4:0], seek=agu_shift_seek_target, cd=0, go to DRAW.
  - Otherwise: rem=tile width (8 or 16), seek=0, cd=agu_x_count−tile width, go to WAIT (or DRAW if cd=0).
  - A first fetch is always issued.
- Fetch rule: bus_vld=1 while (bits=0 and rem>0 and state is WAIT or DRAW) or a fetch is pending; bus_postcount=rem.
- On bus_rdy (not discarded): sr = bus_data >> seek; bits = W_DATA − seek; seek is then cleared.
- WAIT:
  - out_vld=0.
  - Each pixel_advance decrements cd.
  - When cd reaches 0, go to DRAW.
- DRAW:
  - stall = (bits=0 and rem>0).
  - out_vld = (rem>0 and bits>0); out_pix = sr & ((1<<(1<<cfg_log_pixsize))−1).
  - A pixel_advance with out_vld: sr >>= pixsize, bits −= pixsize, rem −= 1.
  - A pixel_advance during stall is ignored (protocol violation by the parent).
  - At rem=0: out_vld=0 and no further fetches.
- Simultaneous bus_rdy and pixel_advance in DRAW with bits=0: the load takes effect, the advance is ignored.

## Timing
- Reset: all outputs 0; state IDLE; all counters 0.
- agu_req rises the cycle after start_line.
- bus_vld rises the cycle after agu_ack (first fetch), and the cycle after bits reaches 0 (refills).
- Data is captured in the bus_rdy cycle; bus_vld drops the following cycle unless another fetch is needed.
- out_vld and out_pix are registered-state derived: valid the cycle after the capture or shift that produces them.

## Test plan
- agu_ack with agu_active=0 -> bus_vld and out_vld stay 0 until the next start_line.
- 8 px, log_pixsize=2, no seek, x_count=12:
  - One fetch with postcount=8; data 0x76543210.
  - After 4 advances, out_pix = 0,1,...,7 on successive advances, then out_vld=0.
  - No second fetch.
- 16 px, log_pixsize=3, seek, x_count=10, seek_target=16:
  - Fetch postcount=10; data 0xDDCCBBAA -> pixels 0xCC, 0xDD.
  - Refill postcount=8, then refill postcount=4.
- Hold bus_rdy low 5 cycles during a DRAW refill -> stall=1 and out_vld=0 for those cycles; advances are ignored and rem is unchanged.
- start_line while a fetch is pending -> bus_vld held until bus_rdy, data not loaded, then agu_req=1 the next cycle.
- rst_n asserted mid-DRAW -> all outputs 0 asynchronously; IDLE after release.
